// File: rtl/lzd_norm_sched.sv
// Shared 64-bit leading-zero detect + normalize unit with round-robin
// arbitration among NREQ requesters, two-stage valid/ready pipeline.

module lz64 (
   input  logic [63:0] a,
   output logic [5:0]  zp,
   output logic        zv
);

   logic [15:0] nib_nz;
   logic [1:0]  nib_lz [16];

   // Per-nibble detectors feed a 16-way priority combine.
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         nib_nz[k] = |a[4*k +: 4];
         casez (a[4*k +: 4])
            4'b1???: nib_lz[k] = 2'd0;
            4'b01??: nib_lz[k] = 2'd1;
            4'b001?: nib_lz[k] = 2'd2;
            default: nib_lz[k] = 2'd3;
         endcase
      end
   end

   // Ascending scan so the most significant nonzero nibble wins.
   always_comb begin
      zp = '0;
      zv = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (nib_nz[k]) begin
            zp = {4'(15 - k), nib_lz[k]};
            zv = 1'b1;
         end
      end
   end

endmodule

module lzd_norm_sched #(
   parameter int NREQ = 2,
   parameter int TAGW = 4,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*64-1:0]   req_mant,
   input  logic [NREQ*TAGW-1:0] req_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          out_mant,
   output logic [5:0]           out_lzc,
   output logic                 out_zero,
   output logic [IDW-1:0]       out_id,
   output logic [TAGW-1:0]      out_tag,
   output logic                 busy
);

   logic [63:0]     mant_arr [NREQ];
   logic [TAGW-1:0] tag_arr  [NREQ];

   logic [IDW-1:0]  rr_ptr, ptr_next, winner;
   logic            win_found, take;

   logic            s1_valid, s2_valid;
   logic [63:0]     s1_mant, s2_mant;
   logic [TAGW-1:0] s1_tag, s2_tag;
   logic [IDW-1:0]  s1_id, s2_id;
   logic [5:0]      s2_lzc;
   logic            s2_zero;

   logic            s2_adv, s1_free;
   logic [5:0]      lz_zp;
   logic            lz_zv;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         mant_arr[i] = req_mant[64*i +: 64];
         tag_arr[i]  = req_tag[TAGW*i +: TAGW];
      end
   end

   assign s2_adv  = s1_valid & (~s2_valid | out_ready);
   assign s1_free = ~s1_valid | s2_adv;

   // Descending offset scan: the last hit is the one closest to rr_ptr.
   always_comb begin
      int idx;
      winner    = '0;
      win_found = 1'b0;
      idx       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[IDW'(idx)]) begin
            winner    = IDW'(idx);
            win_found = 1'b1;
         end
      end
   end

   assign take     = win_found & s1_free & ~reset;
   assign ptr_next = (int'(winner) + 1 >= NREQ) ? '0 : winner + IDW'(1);

   always_comb begin
      req_ready = '0;
      if (take) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr   <= '0;
         s1_valid <= 1'b0;
         s1_mant  <= '0;
         s1_tag   <= '0;
         s1_id    <= '0;
      end else begin
         if (take) rr_ptr <= ptr_next;
         if (s1_free) s1_valid <= take;
         if (take) begin
            s1_mant <= mant_arr[winner];
            s1_tag  <= tag_arr[winner];
            s1_id   <= winner;
         end
      end
   end

   lz64 u_lz64 (
      .a  (s1_mant),
      .zp (lz_zp),
      .zv (lz_zv)
   );

   // S2 data only changes on an advance, which keeps outputs stable under stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_mant  <= '0;
         s2_lzc   <= '0;
         s2_zero  <= 1'b0;
         s2_id    <= '0;
         s2_tag   <= '0;
      end else if (s2_adv) begin
         s2_valid <= 1'b1;
         s2_mant  <= lz_zv ? (s1_mant << lz_zp) : 64'd0;
         s2_lzc   <= lz_zv ? lz_zp : 6'd0;
         s2_zero  <= ~lz_zv;
         s2_id    <= s1_id;
         s2_tag   <= s1_tag;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign out_valid = s2_valid;
   assign out_mant  = s2_mant;
   assign out_lzc   = s2_lzc;
   assign out_zero  = s2_zero;
   assign out_id    = s2_id;
   assign out_tag   = s2_tag;
   assign busy      = s1_valid | s2_valid;

endmodule

// File: doc/lzd_norm_sched.md
# lzd_norm_sched

Pipelined scheduler that shares one 64-bit leading-zero detector and normalizing left shifter among `NREQ` requesters, such as the FP adder lanes. It arbitrates round-robin between requesters, registers the winning mantissa, and counts its leading zeros with the existing hierarchical LZD (`lz64`). It then returns the normalized mantissa, shift count, zero flag, requester ID and tag over a valid/ready output. The block sits between the adder's effective-subtraction stage and the rounding/exponent-adjust stage.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `TAGW`, default 4: width of the opaque per-request tag, carried through unchanged.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input NREQ: request present, one bit per requester.
- `req_ready` output NREQ: request accepted this cycle, one-hot or zero.
- `req_mant` input NREQ*64: mantissa of requester i in bits [64i+63:64i].
- `req_tag` input NREQ*TAGW: tag of requester i in bits [TAGW*i+TAGW-1:TAGW*i].
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_mant` output 64: input shifted left by `out_lzc`; bit 63 is set unless zero.
- `out_lzc` output 6: leading-zero count of the input mantissa.
- `out_zero` output 1: input mantissa was all zeros.
- `out_id` output max(1,$clog2(NREQ)): index of the requester that produced the result.
- `out_tag` output TAGW: tag of that request.
- `busy` output 1: either pipeline stage holds valid data.

## Operation
- **Stage S1 (capture):** registers `s1_valid`, the mantissa, tag and id of the granted request.
- **Stage S2 (result):** `lz64` computes on the S1 mantissa; registers the shifted mantissa, count, zero flag, id, tag and `s2_valid`. S2 drives the `out_*` ports directly.
- **Advance rules:**
  - `s2_adv = s1_valid & (~s2_valid | out_ready)`.
  - `s1_free = ~s1_valid | s2_adv`.
- **Arbitration:** round-robin pointer `rr_ptr`.
  - Winner = the first i with `req_valid[i]` set, scanning `rr_ptr`, `rr_ptr+1`, … mod NREQ.
  - `req_ready[winner] = s1_free`; all other `req_ready` bits are 0.
  - `req_ready` may depend combinationally on `req_valid` and `out_ready`.
- **Transfer:** a transfer occurs when `req_valid[i] & req_ready[i]`. On a transfer, `rr_ptr` becomes (winner+1) mod NREQ. The pointer is unchanged on cycles with no transfer.
- **Count and shift:**
  - Nonzero input: `out_lzc` = lz64 count and `out_mant = mant << lzc`; `out_zero` = 0.
  - All-zero input: `out_lzc` = 0, `out_mant` = 0, `out_zero` = 1. This is consistent with lz64 returning ZP=0, ZV=0.
- **Requester contract:** once `req_valid[i]` is asserted, the requester holds it and its data stable until accepted. The block must not drop or duplicate a request.
- **Output hold:** while `out_valid & ~out_ready`, all `out_*` signals hold stable.
- **`busy`** = `s1_valid | s2_valid`.

## Timing
- **Reset (async assert):**
  - `s1_valid`, `s2_valid`, `out_valid`, `busy` = 0.
  - `rr_ptr` = 0.
  - All data registers = 0, so `out_mant`, `out_lzc`, `out_id`, `out_tag` = 0 and `out_zero` = 0.
  - `req_ready` = 0 while `reset` is high.
  - Release is synchronous to `clk` via the usual reset synchronizer upstream.
- **Latency:** a request accepted in cycle N produces `out_valid` in cycle N+2 when not stalled.
- **Throughput:** one result per cycle with `out_ready` held high.
- **Backpressure:** with `out_ready` low, S2 holds. S1 accepts at most one more request, then `req_ready` goes all-zero. The pipeline holds at most 2 in-flight results, with no loss.
- **Simultaneous events:** consume (`out_valid & out_ready`) and refill in the same cycle is legal.
  - An S1→S2 move and a new S1 capture in the same cycle is legal.
- **Mid-operation reset:** discards all in-flight results; no output appears for them after reset.
- **Pointer wrap:** winner NREQ-1 → `rr_ptr` = 0.

## Test plan
- **Single request, leading zeros:** NREQ=2, req0 mant 0x0000_F000_0000_0000, tag 3, out_ready=1 → 2 cycles later out_valid=1, out_mant=0xF000_0000_0000_0000, out_lzc=16, out_zero=0, out_id=0, out_tag=3.
- **Boundary values:**
  - mant 0x0000_0000_0000_0001 → lzc 63, out_mant 0x8000_0000_0000_0000.
  - mant 0x8000_0000_0000_0000 → lzc 0, mant unchanged.
  - mant 0 → lzc 0, mant 0, out_zero=1.
- **Contention:** req0 and req1 both held valid for 4 transfers from reset → accepted order id 0,1,0,1; `req_ready` one-hot each cycle; results arrive at 1/cycle.
- **Backpressure:** out_ready=0 while 3 requests are pending → exactly 2 accepted, `req_ready`=0 afterward, `out_*` stable. Raising out_ready → 3 results in accept order, tags intact, none duplicated.
- **Mid-operation reset:** assert `reset` with both stages valid → out_valid, busy = 0 immediately. After release, one request → exactly one result at +2 cycles, and the winner search starts at rr_ptr=0.
